// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle control sequencer for the 8-bit accumulator CPU.
// Owns the PC and IR load, and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
module cpu_seq_ctrl #(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned START_PC = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    output logic [PC_W-1:0]  pc_o,
    output logic             ir_load_o,
    input  logic             dec_mem_read_i,
    input  logic             dec_mem_write_i,
    input  logic             dec_reg_write_i,
    input  logic             dec_branch_i,
    input  logic             dec_label_read_i,
    input  logic             dec_halt_i,
    input  logic             alu_zero_i,
    input  logic [PC_W-1:0]  label_target_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    input  logic             mem_ready_i,
    output logic             reg_we_o,
    output logic             busy_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam logic [PC_W-1:0]  START_PC_V = PC_W'(START_PC);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             zero_q, zero_d;
    logic             ir_load_q, ir_load_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic             reg_we_q, reg_we_d;
    logic             busy_q, busy_d;
    logic             halted_q, halted_d;
    logic             launch_c;
    logic             retire_c;
    logic             zero_eff_c;
    logic             take_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flags launch (start honoured) and retire (entry to FETCH after an instruction)
    always_comb begin
        state_d  = state_q;
        launch_c = 1'b0;
        retire_c = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start_i) begin
                    state_d  = S_FETCH;
                    launch_c = 1'b1;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = dec_halt_i ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (dec_mem_read_i || dec_mem_write_i) begin
                    state_d = S_MEM;
                end else if (dec_reg_write_i) begin
                    state_d = S_WB;
                end else begin
                    state_d  = S_FETCH;
                    retire_c = 1'b1;
                end
            end
            S_MEM: begin
                if (mem_ready_i) begin
                    if (dec_reg_write_i) begin
                        state_d = S_WB;
                    end else begin
                        state_d  = S_FETCH;
                        retire_c = 1'b1;
                    end
                end
            end
            S_WB: begin
                state_d  = S_FETCH;
                retire_c = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // PC, retired counter and captured zero flag; retiring straight out of EXEC uses the live flag
    always_comb begin
        pc_d       = pc_q;
        retired_d  = retired_q;
        zero_d     = zero_q;
        zero_eff_c = (state_q == S_EXEC) ? alu_zero_i : zero_q;
        take_c     = dec_label_read_i && (!dec_branch_i || zero_eff_c);
        if (state_q == S_EXEC) begin
            zero_d = alu_zero_i;
        end
        if (launch_c) begin
            pc_d      = START_PC_V;
            retired_d = '0;
        end else if (retire_c) begin
            pc_d = take_c ? label_target_i : pc_q + PC_W'(1);
            if (retired_q != CNT_MAX) begin
                retired_d = retired_q + CNT_W'(1);
            end
        end
    end

    // Output decode from the next state so every strobe is a flop aligned with its state
    always_comb begin
        ir_load_d = 1'b0;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        reg_we_d  = 1'b0;
        busy_d    = 1'b0;
        halted_d  = 1'b0;
        case (state_d)
            S_FETCH: begin
                ir_load_d = 1'b1;
                busy_d    = 1'b1;
            end
            S_DECODE, S_EXEC: begin
                busy_d = 1'b1;
            end
            S_MEM: begin
                mem_req_d = 1'b1;
                mem_we_d  = dec_mem_write_i;
                busy_d    = 1'b1;
            end
            S_WB: begin
                reg_we_d = 1'b1;
                busy_d   = 1'b1;
            end
            S_HALT: begin
                halted_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= START_PC_V;
            retired_q <= '0;
            zero_q    <= 1'b0;
            ir_load_q <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            reg_we_q  <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            retired_q <= retired_d;
            zero_q    <= zero_d;
            ir_load_q <= ir_load_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            reg_we_q  <= reg_we_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
        end
    end

    assign pc_o      = pc_q;
    assign retired_o = retired_q;
    assign ir_load_o = ir_load_q;
    assign mem_req_o = mem_req_q;
    assign mem_we_o  = mem_we_q;
    assign reg_we_o  = reg_we_q;
    assign busy_o    = busy_q;
    assign halted_o  = halted_q;

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
Multi-cycle control sequencer for the 8-bit accumulator-style CPU datapath. It owns the PC and instruction-register load, and steps every instruction through FETCH/DECODE/EXEC/MEM/WB using the control fields produced by the instruction decoder. It resolves branch/jump targets through the external label table, handshakes with data memory, and stops cleanly on halt.

Parameters:
PC_W, 8, width of program counter and label targets
START_PC, 0, PC value loaded on start
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_i  in  1  launch pulse; honoured only in IDLE or HALT
pc_o  out  PC_W  current program counter, address to instruction ROM
ir_load_o  out  1  load instruction register from ROM at this edge
dec_mem_read_i  in  1  decoder memRead for instruction held in IR
dec_mem_write_i  in  1  decoder memWrite
dec_reg_write_i  in  1  decoder regWrite
dec_branch_i  in  1  decoder branch (conditional)
dec_label_read_i  in  1  decoder labelRead (branch or jump)
dec_halt_i  in  1  decoder halt
alu_zero_i  in  1  ALU zero flag, valid in EXEC
label_target_i  in  PC_W  label table output for decoder branchAddr
mem_req_o  out  1  data memory request
mem_we_o  out  1  data memory write enable, qualified by mem_req_o
mem_ready_i  in  1  data memory completion
reg_we_o  out  1  register file write strobe
busy_o  out  1  high in any state except IDLE and HALT
halted_o  out  1  high in HALT
retired_o  out  CNT_W  retired-instruction count, saturating

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc_o=START_PC, retired_o=0; all strobes (ir_load_o, mem_req_o, mem_we_o, reg_we_o) 0, busy_o=0, halted_o=0.
- All outputs registered or decoded from state only; no input-to-output combinational path.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: start_i=1 -> pc=START_PC, retired=0, go FETCH.
- FETCH: ir_load_o=1 one cycle -> DECODE.
- DECODE: dec_halt_i=1 -> HALT (other decoder fields ignored, may be X). Else -> EXEC.
- EXEC: mem_read|mem_write -> MEM; else reg_write -> WB; else retire -> FETCH.
- MEM: mem_req_o=1, mem_we_o=dec_mem_write_i; hold until mem_ready_i=1 (no timeout). On ready: reg_write -> WB, else retire -> FETCH. mem_ready_i outside MEM ignored.
- WB: reg_we_o=1 one cycle; retire -> FETCH.
- Retire (transition into FETCH from EXEC/MEM/WB): retired_o += 1, saturating at all-ones; PC update:
  - label_read & !branch (jump): pc = label_target_i.
  - label_read & branch: pc = label_target_i if alu_zero_i sampled in EXEC was 1, else pc+1. Zero flag captured at EXEC exit and used at retire.
  - otherwise pc = pc+1, wraps modulo 2^PC_W.
- Latency: no-write ALU/branch/jump 3 cycles; reg-writing ALU 4; store 4+wait; load 5+wait (wait = cycles with mem_ready_i=0 in MEM).
- HALT: halted_o=1, pc frozen at halt instruction address, retired frozen (halt not counted). start_i=1 -> pc=START_PC, retired=0, FETCH.
- start_i while busy: ignored.
- Reset mid-instruction (incl. MEM with request pending): immediate return to IDLE, strobes drop asynchronously; memory must tolerate an abandoned request.

Test Plan:
- Reset then start_i pulse with ROM {add, add, halt} -> pc 0,1,2; reg_we_o high in cycles 4 and 8; halted_o=1 at cycle 11, pc_o=2, retired_o=2.
- ld at pc 5, mem_ready_i low 3 cycles -> mem_req_o high 4 cycles, mem_we_o=0, then reg_we_o one cycle, pc_o=6.
- st: mem_we_o=1 with mem_req_o, no reg_we_o, retires in 4 cycles with ready immediate.
- beq0 at pc 3, label_target_i=0x0A: alu_zero_i=1 -> pc_o=0x0A; alu_zero_i=0 -> pc_o=4; j always -> 0x0A.
- PC_W=4, linear code at pc 15 -> wraps to 0; retired_o saturates at 0xFFFF with CNT_W=16 preloaded run.
- rst_n low during MEM wait -> mem_req_o=0 same cycle, state IDLE, pc_o=START_PC; start_i in FETCH ignored.
